// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequences the operand beats for one PE output element.
//
// A start in IDLE latches the kernel/channel-group counts and base address,
// then streams cfg_kk*cfg_cg beats to the PE (cg inner, kk outer), waits for
// the accumulated result, and holds it for the consumer until res_ready.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   start                one-cycle job request (honoured only in IDLE)
//   cfg_kk/cfg_cg/cfg_base  job configuration, latched on an accepted start
//   buf_rdy              operand buffer can supply a beat this cycle
//   pe_in_*              beat issue towards the PE
//   pe_out_valid/data    PE accumulation result
//   res_valid/data/ready result handshake towards the consumer
//   busy, done, err      status: not idle, job-complete pulse, sticky error
module pe_seq_ctrl #(
  parameter int unsigned DATA_WID = 16,
  parameter int unsigned ADDR_B   = 10,
  parameter int unsigned CNT_B    = 8,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_B-1:0]    cfg_kk,
  input  logic [CNT_B-1:0]    cfg_cg,
  input  logic [ADDR_B-1:0]   cfg_base,
  input  logic                buf_rdy,
  output logic                pe_in_valid,
  output logic                pe_in_first,
  output logic                pe_in_last,
  output logic [ADDR_B-1:0]   pe_in_addr,
  input  logic                pe_out_valid,
  input  logic [DATA_WID-1:0] pe_out_data,
  output logic                res_valid,
  output logic [DATA_WID-1:0] res_data,
  input  logic                res_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned IdxW = 2 * CNT_B;
  // Drain timer runs 1..PIPE_LAT+2 counting cycles since the last beat.
  localparam int unsigned LatW = $clog2(PIPE_LAT + 3);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StHold} state_e;

  state_e              state_q;
  logic [CNT_B-1:0]    kk_q, cg_q;
  logic [CNT_B-1:0]    kk_cnt_q, cg_cnt_q;
  logic [IdxW-1:0]     beat_idx_q;
  logic [ADDR_B-1:0]   addr_q;
  logic [LatW-1:0]     lat_q;
  logic                res_valid_q;
  logic [DATA_WID-1:0] res_data_q;
  logic                done_q;
  logic                err_q;

  logic beat;
  logic last_beat;
  logic cfg_bad;

  // A beat goes out in the same cycle the buffer offers one, so the issue
  // strobes are the registered state gated by buf_rdy.
  assign beat      = (state_q == StIssue) && buf_rdy;
  assign last_beat = (cg_cnt_q == cg_q - CNT_B'(1)) && (kk_cnt_q == kk_q - CNT_B'(1));
  assign cfg_bad   = (cfg_kk == '0) || (cfg_cg == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      kk_q        <= '0;
      cg_q        <= '0;
      kk_cnt_q    <= '0;
      cg_cnt_q    <= '0;
      beat_idx_q  <= '0;
      addr_q      <= '0;
      lat_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_bad) begin
              // Degenerate job: report and finish without leaving IDLE.
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              kk_q       <= cfg_kk;
              cg_q       <= cfg_cg;
              addr_q     <= cfg_base;
              kk_cnt_q   <= '0;
              cg_cnt_q   <= '0;
              beat_idx_q <= '0;
              lat_q      <= '0;
              err_q      <= 1'b0;
              state_q    <= StIssue;
            end
          end
        end
        StIssue: begin
          if (beat) begin
            addr_q     <= addr_q + ADDR_B'(1);
            beat_idx_q <= beat_idx_q + IdxW'(1);
            if (cg_cnt_q == cg_q - CNT_B'(1)) begin
              cg_cnt_q <= '0;
              kk_cnt_q <= kk_cnt_q + CNT_B'(1);
            end else begin
              cg_cnt_q <= cg_cnt_q + CNT_B'(1);
            end
            if (last_beat) begin
              lat_q   <= LatW'(1);
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (pe_out_valid) begin
            res_data_q  <= pe_out_data;
            res_valid_q <= 1'b1;
            state_q     <= StHold;
          end else if (lat_q == LatW'(PIPE_LAT + 2)) begin
            // PE never answered: hand back a zero result flagged by err.
            err_q       <= 1'b1;
            res_data_q  <= '0;
            res_valid_q <= 1'b1;
            state_q     <= StHold;
          end else begin
            lat_q <= lat_q + LatW'(1);
          end
        end
        StHold: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pe_in_valid = beat;
  assign pe_in_first = beat && (beat_idx_q == '0);
  assign pe_in_last  = beat && last_beat;
  assign pe_in_addr  = addr_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed self-checking bench for pe_seq_ctrl (default parameters).
module tb_pe_seq_ctrl;

  localparam int PipeLat = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  cfg_kk;
  logic [7:0]  cfg_cg;
  logic [9:0]  cfg_base;
  logic        buf_rdy;
  logic        pe_in_valid;
  logic        pe_in_first;
  logic        pe_in_last;
  logic [9:0]  pe_in_addr;
  logic        pe_out_valid;
  logic [15:0] pe_out_data;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fails  = 0;

  pe_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_kk       (cfg_kk),
    .cfg_cg       (cfg_cg),
    .cfg_base     (cfg_base),
    .buf_rdy      (buf_rdy),
    .pe_in_valid  (pe_in_valid),
    .pe_in_first  (pe_in_first),
    .pe_in_last   (pe_in_last),
    .pe_in_addr   (pe_in_addr),
    .pe_out_valid (pe_out_valid),
    .pe_out_data  (pe_out_data),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs sampled 1 ns later, both well away from the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, pe_in_valid, 0);
    check_eq({tag, "_first"}, pe_in_first, 0);
    check_eq({tag, "_last"}, pe_in_last, 0);
    check_eq({tag, "_addr"}, pe_in_addr, 0);
    check_eq({tag, "_res_valid"}, res_valid, 0);
    check_eq({tag, "_res_data"}, res_data, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err, 0);
  endtask

  // Run one job. rdy_pat bit i is buf_rdy for the i-th cycle after start
  // (1 beyond rdy_len). pe_lat: cycles from last beat to pe_out_valid, 0 for
  // never. ready_dly: HOLD cycles with res_ready low before accepting.
  // While busy, start is pulsed with junk config to prove it is ignored.
  task automatic run_job(input logic [7:0] kk, input logic [7:0] cg, input logic [9:0] base,
                         input logic [31:0] rdy_pat, input int rdy_len, input int pe_lat,
                         input logic [15:0] pe_data, input int ready_dly);
    int          total;
    int          beats;
    int          last_cyc;
    int          hold_cyc;
    bit          done_seen;
    logic [9:0]  exp_addr;
    logic [15:0] exp_res;
    total     = int'(kk) * int'(cg);
    beats     = 0;
    last_cyc  = -1;
    hold_cyc  = 0;
    done_seen = 1'b0;
    exp_addr  = base;
    exp_res   = (pe_lat > 0) ? pe_data : 16'h0000;

    next_cycle();
    start    = 1'b1;
    cfg_kk   = kk;
    cfg_cg   = cg;
    cfg_base = base;
    buf_rdy  = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      next_cycle();
      start        = busy;
      cfg_kk       = 8'h03;
      cfg_cg       = 8'h03;
      cfg_base     = 10'h155;
      buf_rdy      = (cyc < rdy_len) ? rdy_pat[cyc] : 1'b1;
      // Junk PE results while HOLD must not disturb the held result.
      pe_out_valid = ((last_cyc >= 0) && (pe_lat > 0) && (cyc == last_cyc + pe_lat)) || res_valid;
      pe_out_data  = ((last_cyc >= 0) && (pe_lat > 0) && (cyc == last_cyc + pe_lat)) ?
                     pe_data : 16'hDEAD;
      res_ready    = res_valid && (hold_cyc >= ready_dly);
      #1;
      if (cyc == 0) check_eq("busy_after_start", busy, 1);
      if (pe_in_valid) begin
        check_eq("beat_on_rdy", buf_rdy, 1);
        check_eq("beat_addr", pe_in_addr, exp_addr);
        check_eq("beat_first", pe_in_first, (beats == 0));
        check_eq("beat_last", pe_in_last, (beats == total - 1));
        if (pe_in_last) last_cyc = cyc;
        beats++;
        exp_addr = exp_addr + 10'd1;
      end
      if (res_valid) begin
        if (hold_cyc == 0) begin
          check_eq("res_latency", cyc - last_cyc, (pe_lat > 0) ? pe_lat + 1 : PipeLat + 3);
          check_eq("res_err", err, (pe_lat == 0));
        end
        check_eq("res_data", res_data, exp_res);
        hold_cyc++;
      end
      if (done) begin
        check_eq("done_res_valid", res_valid, 0);
        check_eq("done_busy", busy, 0);
        done_seen = 1'b1;
        break;
      end
    end
    check_eq("job_done", done_seen, 1);
    check_eq("beat_count", beats, total);
    check_eq("hold_cycles", hold_cyc, ready_dly + 1);
    next_cycle();
    start        = 1'b0;
    buf_rdy      = 1'b0;
    pe_out_valid = 1'b0;
    res_ready    = 1'b0;
    #1;
    check_eq("start_dropped", busy, 0);
    check_eq("done_single", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    cfg_kk       = '0;
    cfg_cg       = '0;
    cfg_base     = '0;
    buf_rdy      = 1'b0;
    pe_out_valid = 1'b0;
    pe_out_data  = '0;
    res_ready    = 1'b0;
    next_cycle();
    next_cycle();
    check_all_zero("reset");
    reset = 1'b1;
    next_cycle();
    #1;
    check_all_zero("post_reset");

    // Nominal 9x2 job, PE answers 3 cycles after the last beat.
    run_job(8'd9, 8'd2, 10'h010, 32'h0, 0, 3, 16'h1234, 0);
    // Stall pattern 1,0,0,1,1,0,1.
    run_job(8'd1, 8'd4, 10'h040, 32'h59, 7, 3, 16'h0BEE, 0);

    // kk=0: error and done pulse, no beats.
    next_cycle();
    start   = 1'b1;
    cfg_kk  = 8'd0;
    cfg_cg  = 8'd2;
    buf_rdy = 1'b1;
    next_cycle();
    start = 1'b0;
    #1;
    check_eq("kk0_done", done, 1);
    check_eq("kk0_err", err, 1);
    check_eq("kk0_busy", busy, 0);
    check_eq("kk0_valid", pe_in_valid, 0);
    next_cycle();
    #1;
    check_eq("kk0_done_once", done, 0);
    check_eq("kk0_err_sticky", err, 1);
    check_eq("kk0_valid2", pe_in_valid, 0);

    // Single beat job; also clears err.
    run_job(8'd1, 8'd1, 10'h123, 32'h0, 0, 2, 16'h00C3, 0);
    // Address wrap with consumer backpressure.
    run_job(8'd1, 8'd4, 10'h3FE, 32'h0, 0, 3, 16'h5A5A, 5);
    // PE never answers: timeout.
    run_job(8'd1, 8'd2, 10'h200, 32'h0, 0, 0, 16'h0000, 1);
    check_eq("timeout_err_sticky", err, 1);

    // Reset after beat 3 of 18.
    next_cycle();
    start    = 1'b1;
    cfg_kk   = 8'd9;
    cfg_cg   = 8'd2;
    cfg_base = 10'h010;
    buf_rdy  = 1'b1;
    next_cycle();
    start = 1'b0;
    begin
      int beats;
      beats = 0;
      for (int cyc = 0; cyc < 20 && beats < 3; cyc++) begin
        #1;
        if (pe_in_valid) beats++;
        if (beats < 3) next_cycle();
      end
      check_eq("rst_beats_before", beats, 3);
    end
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    next_cycle();
    #1;
    check_all_zero("mid_reset_held");
    reset   = 1'b1;
    buf_rdy = 1'b0;
    next_cycle();
    #1;
    check_eq("after_reset_done", done, 0);
    check_eq("after_reset_busy", busy, 0);
    run_job(8'd9, 8'd2, 10'h010, 32'h0, 0, 3, 16'h4321, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
